// File: rtl/edf_label_writer_pkg.sv
// Shared widths, types and the EDF label helper for the label writer.
package edf_label_pkg;

  localparam int LABEL_W   = 8;
  localparam int DATA_W    = 8;
  localparam int FLOW_W    = 2;
  localparam int NUM_FLOWS = 1 << FLOW_W;
  localparam int CNT_W     = 16;

  typedef logic [LABEL_W-1:0] label_t;
  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [FLOW_W-1:0]  flow_t;

  // Packing matches the FIFO din port: label in the upper bits, data below.
  typedef struct packed {
    label_t label;
    data_t  data;
  } fifo_entry_t;

  // Absolute deadline; wraps modulo 2**LABEL_W, never saturates.
  function automatic label_t edf_label(input label_t t, input label_t dl);
    return t + dl;
  endfunction

endpackage

// File: rtl/edf_label_writer_if.sv
// Ingress, config and FIFO write-side signals of the label writer.
interface edf_label_writer_if;
  import edf_label_pkg::*;

  logic                in_valid;
  logic                in_ready;
  flow_t               in_flow;
  data_t               in_data;
  logic                cfg_we;
  flow_t               cfg_flow;
  label_t              cfg_dl;
  logic                fifo_full;
  logic                we;
  fifo_entry_t         din;
  label_t              now;
  logic [CNT_W-1:0]    push_cnt;

  // Label writer side.
  modport slave (
    input  in_valid, in_flow, in_data, cfg_we, cfg_flow, cfg_dl, fifo_full,
    output in_ready, we, din, now, push_cnt
  );

  // Traffic source / FIFO side.
  modport master (
    output in_valid, in_flow, in_data, cfg_we, cfg_flow, cfg_dl, fifo_full,
    input  in_ready, we, din, now, push_cnt
  );

endinterface

// File: rtl/edf_label_writer_dl_table.sv
// Per-flow relative deadline register file: one cfg write port, one async read.
module edf_dl_table
  import edf_label_pkg::*;
#(
  parameter label_t DEFAULT_DL = label_t'(16)
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   we_i,
  input  flow_t  waddr_i,
  input  label_t wdata_i,
  input  flow_t  raddr_i,
  output label_t rdata_o
);

  label_t [NUM_FLOWS-1:0] tbl_q;

  // Entries reload the default deadline on reset; cfg writes land at the edge,
  // so a same-edge reader still sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FLOWS; i++) tbl_q[i] <= DEFAULT_DL;
    end else if (we_i) begin
      tbl_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = tbl_q[raddr_i];

endmodule

// File: rtl/edf_label_writer.sv
// EDF label writer: stamps each payload with arrival time + per-flow deadline
// and pushes {label,data} into the priority FIFO through a 2-stage pipeline.
module edf_label_writer
  import edf_label_pkg::*;
#(
  parameter int unsigned DEFAULT_DL = 16,
  parameter int unsigned TICK_DIV   = 1
) (
  input logic               clk,
  input logic               rst,
  edf_label_writer_if.slave bus
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Time base
  logic [DIV_W-1:0] div_q, div_d;
  label_t           now_q, now_d;
  logic             tick;

  // Stage 1: captured arrival time and looked-up relative deadline
  logic        s1_full_q, s1_full_d;
  data_t       s1_data_q, s1_data_d;
  label_t      s1_time_q, s1_time_d;
  label_t      s1_dl_q,   s1_dl_d;

  // Stage 2: finished FIFO entry
  logic        s2_full_q, s2_full_d;
  fifo_entry_t s2_entry_q, s2_entry_d;

  logic [CNT_W-1:0] push_cnt_q, push_cnt_d;

  logic   s2_moves, s1_moves, s1_open, accept, we_int;
  label_t tbl_dl;

  edf_dl_table #(
    .DEFAULT_DL(label_t'(DEFAULT_DL))
  ) u_dl_table (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bus.cfg_we),
    .waddr_i (bus.cfg_flow),
    .wdata_i (bus.cfg_dl),
    .raddr_i (bus.in_flow),
    .rdata_o (tbl_dl)
  );

  // Handshake: a stage opens when it is empty or its content leaves this edge.
  always_comb begin
    s2_moves = s2_full_q && !bus.fifo_full;
    s1_moves = !s2_full_q || s2_moves;
    s1_open  = !s1_full_q || s1_moves;
    accept   = bus.in_valid && s1_open && !rst;
    we_int   = s2_full_q && !bus.fifo_full;
  end

  // Next state: time base, pipeline advance and push counter.
  always_comb begin
    tick       = (div_q == DIV_W'(TICK_DIV - 1));
    div_d      = tick ? '0 : div_q + 1'b1;
    now_d      = tick ? now_q + 1'b1 : now_q;

    s1_full_d  = s1_full_q;
    s1_data_d  = s1_data_q;
    s1_time_d  = s1_time_q;
    s1_dl_d    = s1_dl_q;
    if (s1_open) begin
      s1_full_d = accept;
      if (accept) begin
        s1_data_d = bus.in_data;
        s1_time_d = now_q;
        s1_dl_d   = tbl_dl;
      end
    end

    s2_full_d  = s2_full_q;
    s2_entry_d = s2_entry_q;
    if (s1_moves) begin
      s2_full_d = s1_full_q;
      if (s1_full_q) begin
        s2_entry_d.label = edf_label(s1_time_q, s1_dl_q);
        s2_entry_d.data  = s1_data_q;
      end
    end

    push_cnt_d = push_cnt_q + CNT_W'(we_int);
  end

  // State registers; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      now_q      <= '0;
      s1_full_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_time_q  <= '0;
      s1_dl_q    <= '0;
      s2_full_q  <= 1'b0;
      s2_entry_q <= '0;
      push_cnt_q <= '0;
    end else begin
      div_q      <= div_d;
      now_q      <= now_d;
      s1_full_q  <= s1_full_d;
      s1_data_q  <= s1_data_d;
      s1_time_q  <= s1_time_d;
      s1_dl_q    <= s1_dl_d;
      s2_full_q  <= s2_full_d;
      s2_entry_q <= s2_entry_d;
      push_cnt_q <= push_cnt_d;
    end
  end

  assign bus.in_ready = s1_open && !rst;
  assign bus.we       = we_int;
  assign bus.din      = s2_entry_q;
  assign bus.now      = now_q;
  assign bus.push_cnt = push_cnt_q;

endmodule
